alu_share_arbiter: RTL and testbench

Round-robin arbiter that time-shares the single nibble-serial ALU between N requesters, for example the PC-increment path and the instruction-execute path of the control FSM. It grants one requester at a time and registers that requester's ctrl and operands. It then sequences the ALU's `perm_to_count`/`busy` handshake and returns the result with a one-cycle `done` pulse. It sits between the control unit's datapath requesters and the ALU, replacing the direct drive of `alu_w1`/`alu_w2`/`perm_to_count`.

---
 rtl/ctrl_pkg.sv | 25 ++
 rtl/rr_pick.sv | 28 ++
 rtl/alu_share_arbiter.sv | 109 ++++++++++
 tb/tb_alu_share_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-unit types: ALU command encoding and arbiter states.
// Imported by the ALU share arbiter and its round-robin picker.
package ctrl_pkg;

  localparam int CTRL_W = 3;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLL  = 3'd5,
    ALU_SRL  = 3'd6,
    ALU_PASS = 3'd7
  } AluCtrl;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } ArbState;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// The search starts one past the last winner, so that winner has lowest priority.
module rr_pick #(
  parameter  int N_REQ = 2,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    pick_idx,
  output logic             any
);

  int j;

  // Walk from the farthest offset down so the nearest requester wins.
  always_comb begin
    pick_idx = '0;
    j        = 0;
    any      = |req;
    for (int i = N_REQ; i >= 1; i--) begin
      j = (int'(last) + i) % N_REQ;
      if (req[j]) pick_idx = IW'(j);
    end
    pick = any ? (N_REQ'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares the nibble-serial ALU between N_REQ requesters.
// Grants round-robin, drives the perm/busy handshake and returns the result.
module alu_share_arbiter
  import ctrl_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int ISSUE_TIMEOUT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0][CTRL_W-1:0]  req_ctrl,
  input  logic [N_REQ-1:0][31:0]        req_w1,
  input  logic [N_REQ-1:0][31:0]        req_w2,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              done,
  output logic                          err,
  output logic [31:0]                   result,
  output logic [CTRL_W-1:0]             alu_ctrl,
  output logic [31:0]                   alu_w1,
  output logic [31:0]                   alu_w2,
  output logic                          alu_perm_to_count,
  input  logic                          alu_busy,
  input  logic [31:0]                   alu_result
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(ISSUE_TIMEOUT + 1);

  ArbState          state;
  logic [IW-1:0]    last;
  logic [IW-1:0]    cur;
  logic [TW-1:0]    tmo;
  logic [TW-1:0]    tmo_nxt;
  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             any;

  assign tmo_nxt = tmo + TW'(1);

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (req),
    .last     (last),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      last              <= IW'(N_REQ - 1);
      cur               <= '0;
      tmo               <= '0;
      gnt               <= '0;
      done              <= '0;
      err               <= 1'b0;
      result            <= '0;
      alu_ctrl          <= '0;
      alu_w1            <= '0;
      alu_w2            <= '0;
      alu_perm_to_count <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            alu_ctrl          <= req_ctrl[pick_idx];
            alu_w1            <= req_w1[pick_idx];
            alu_w2            <= req_w2[pick_idx];
            gnt               <= pick;
            cur               <= pick_idx;
            last              <= pick_idx;
            tmo               <= '0;
            alu_perm_to_count <= 1'b1;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          if (alu_busy) begin
            alu_perm_to_count <= 1'b0;
            state             <= WAIT;
          end else if (tmo_nxt == TW'(ISSUE_TIMEOUT)) begin
            alu_perm_to_count <= 1'b0;
            result            <= '0;
            err               <= 1'b1;
            done              <= N_REQ'(1) << cur;
            state             <= DONE;
          end else begin
            tmo <= tmo_nxt;
          end
        end
        WAIT: begin
          // perm stays low here so the ALU cannot restart on its own.
          if (!alu_busy) begin
            result <= alu_result;
            done   <= N_REQ'(1) << cur;
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter.
// A transaction-level model predicts grants, completions and results.
module tb_alu_share_arbiter;
  import ctrl_pkg::*;

  localparam int N  = 2;
  localparam int TO = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N-1:0]          req = '0;
  logic [N-1:0][2:0]     req_ctrl = '0;
  logic [N-1:0][31:0]    req_w1 = '0;
  logic [N-1:0][31:0]    req_w2 = '0;
  logic [N-1:0]          gnt;
  logic [N-1:0]          done;
  logic                  err;
  logic [31:0]           result;
  logic [2:0]            alu_ctrl;
  logic [31:0]           alu_w1;
  logic [31:0]           alu_w2;
  logic                  alu_perm_to_count;
  logic                  alu_busy = 1'b0;
  logic [31:0]           alu_result = '0;

  int n_chk  = 0;
  int n_fail = 0;

  int busy_len   = 3;
  bit never_busy = 1'b0;
  int alu_cnt    = 0;

  alu_share_arbiter #(.N_REQ(N), .ISSUE_TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .req_ctrl          (req_ctrl),
    .req_w1            (req_w1),
    .req_w2            (req_w2),
    .gnt               (gnt),
    .done              (done),
    .err               (err),
    .result            (result),
    .alu_ctrl          (alu_ctrl),
    .alu_w1            (alu_w1),
    .alu_w2            (alu_w2),
    .alu_perm_to_count (alu_perm_to_count),
    .alu_busy          (alu_busy),
    .alu_result        (alu_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_fn(input logic [2:0] c,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return a;
    endcase
  endfunction

  function automatic int rr(input logic [N-1:0] r, input int lst);
    for (int i = 1; i <= N; i++)
      if (r[(lst + i) % N]) return (lst + i) % N;
    return -1;
  endfunction

  // ALU stand-in: starts on perm, stays busy for busy_len cycles.
  always @(posedge clk) begin
    if (alu_cnt != 0) begin
      alu_cnt <= alu_cnt - 1;
      if (alu_cnt == 1) alu_busy <= 1'b0;
    end else if (alu_perm_to_count && !alu_busy && !never_busy) begin
      alu_busy   <= 1'b1;
      alu_cnt    <= busy_len;
      alu_result <= alu_fn(alu_ctrl, alu_w1, alu_w2);
    end
  end

  // Transaction-level reference model, evaluated mid-cycle.
  logic [N-1:0]       req_s;
  logic [N-1:0][2:0]  ctrl_s;
  logic [N-1:0][31:0] w1_s, w2_s;
  bit                 grant_ok_s = 1'b0;
  bit                 outst = 1'b0;
  bit                 perm_m = 1'b0;
  bit                 exp_err = 1'b0;
  int                 last_m = N - 1;
  int                 cur_m = 0;
  int                 age = 0;
  int                 lat = 0;
  int                 issue_n = 0;
  logic [31:0]        exp_res, w1_m;
  logic [N-1:0]       exp_g, exp_d;

  always @(negedge clk) begin
    if (rst) begin
      outst      = 1'b0;
      perm_m     = 1'b0;
      last_m     = N - 1;
      grant_ok_s = 1'b0;
    end else begin
      exp_g = '0;
      if (grant_ok_s && req_s != '0) exp_g[rr(req_s, last_m)] = 1'b1;
      check("gnt", 32'(gnt), 32'(exp_g));
      if (exp_g != '0) begin
        cur_m = rr(req_s, last_m);
        last_m = cur_m;
        check("alu_w1_cap", alu_w1, w1_s[cur_m]);
        check("alu_w2_cap", alu_w2, w2_s[cur_m]);
        check("alu_ctrl_cap", 32'(alu_ctrl), 32'(ctrl_s[cur_m]));
        outst   = 1'b1;
        age     = 0;
        w1_m    = w1_s[cur_m];
        exp_err = never_busy;
        exp_res = never_busy ? 32'h0 :
                  alu_fn(ctrl_s[cur_m], w1_s[cur_m], w2_s[cur_m]);
        lat     = never_busy ? TO : busy_len + 2;
        perm_m  = 1'b1;
        issue_n = 0;
      end else if (outst) begin
        age++;
        check("alu_w1_hold", alu_w1, w1_m);
      end
      exp_d = '0;
      if (outst && age == lat) exp_d[cur_m] = 1'b1;
      check("done", 32'(done), 32'(exp_d));
      check("err", 32'(err), 32'(exp_d != '0 && exp_err));
      if (exp_d != '0) begin
        check("result", result, exp_res);
        outst = 1'b0;
      end
      check("perm", 32'(alu_perm_to_count), 32'(perm_m));
      if (perm_m) begin
        if (alu_busy) perm_m = 1'b0;
        else begin
          issue_n++;
          if (issue_n == TO) perm_m = 1'b0;
        end
      end
      grant_ok_s = !outst && exp_d == '0;
    end
    req_s  = req;
    ctrl_s = req_ctrl;
    w1_s   = req_w1;
    w2_s   = req_w2;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic [N-1:0] g, output int n);
    n = 0;
    @(negedge clk);
    while (gnt == '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    g = gnt;
    if (gnt == '0) check("gnt_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_done(output logic [N-1:0] d, output logic e,
                           output logic [31:0] r, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < 60);
    d = done;
    e = err;
    r = result;
    if (done == '0) check("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [N-1:0] g, d;
  logic         e;
  logic [31:0]  r;
  int           n;

  initial begin
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_result", result, 32'(0));
    check("rst_w1", alu_w1, 32'(0));
    check("rst_perm", 32'(alu_perm_to_count), 32'(0));
    step();
    rst = 1'b0;

    // Single request: 0x10 + 1, ALU busy 8 cycles.
    busy_len  = 8;
    req_ctrl[0] = ALU_ADD;
    req_w1[0] = 32'h10;
    req_w2[0] = 32'h1;
    req = 2'b01;
    wait_gnt(g, n);
    check("single_gnt", 32'(g), 32'(1));
    check("single_gnt_lat", 32'(n), 32'(1));
    step();
    req = '0;
    wait_done(d, e, r, n);
    check("single_done", 32'(d), 32'(1));
    check("single_res", r, 32'h11);
    check("single_err", 32'(e), 32'(0));
    check("single_lat", 32'(n), 32'(10));

    // Contention after reset with both requests held.
    do_reset();
    busy_len = 3;
    req_w1[0] = 32'd5; req_w2[0] = 32'd3; req_ctrl[0] = ALU_ADD;
    req_w1[1] = 32'd7; req_w2[1] = 32'd1; req_ctrl[1] = ALU_ADD;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g, n);
      check("cont_gnt", 32'(g), (k % 2 == 0) ? 32'(1) : 32'(2));
      wait_done(d, e, r, n);
      check("cont_done", 32'(d), 32'(g));
      check("cont_res", r, 32'd8);
    end
    step();
    req = '0;
    repeat (3) step();

    // Operands are captured on grant only.
    req_w1[1] = 32'h100; req_w2[1] = 32'h1;
    req = 2'b10;
    wait_gnt(g, n);
    step();
    req_w1[1] = 32'hFFFF;
    req = '0;
    wait_done(d, e, r, n);
    check("cap_done", 32'(d), 32'(2));
    check("cap_res", r, 32'h101);
    check("cap_w1", alu_w1, 32'h100);
    repeat (2) step();

    // ALU never answers: timeout completion.
    never_busy = 1'b1;
    req = 2'b01;
    wait_gnt(g, n);
    step();
    req = '0;
    wait_done(d, e, r, n);
    check("to_done", 32'(d), 32'(1));
    check("to_err", 32'(e), 32'(1));
    check("to_res", r, 32'(0));
    check("to_lat", 32'(n), 32'(TO));
    step();
    never_busy = 1'b0;
    repeat (2) step();

    // Reset while the ALU is busy.
    busy_len = 10;
    req_w1[0] = 32'h1234;
    req = 2'b01;
    wait_gnt(g, n);
    step();
    req = '0;
    repeat (4) step();
    #2;
    rst = 1'b1;
    #1;
    check("mid_gnt", 32'(gnt), 32'(0));
    check("mid_done", 32'(done), 32'(0));
    check("mid_result", result, 32'(0));
    check("mid_w1", alu_w1, 32'(0));
    check("mid_perm", 32'(alu_perm_to_count), 32'(0));
    n = 0;
    while (alu_busy && n < 40) begin
      step();
      n++;
    end
    busy_len = 2;
    step();
    rst = 1'b0;
    req = 2'b11;
    wait_gnt(g, n);
    check("mid_first_gnt", 32'(g), 32'(1));
    step();
    req = '0;
    wait_done(d, e, r, n);

    // Request dropped right after grant.
    req_w1[0] = 32'h20; req_w2[0] = 32'h22; req_ctrl[0] = ALU_XOR;
    req = 2'b01;
    wait_gnt(g, n);
    step();
    req = '0;
    wait_done(d, e, r, n);
    check("drop_done", 32'(d), 32'(1));
    check("drop_res", r, 32'h02);
    repeat (4) step();

    // Randomized traffic; the model does the checking.
    for (int c = 0; c < 600; c++) begin
      step();
      req = N'($urandom_range(0, 3));
      busy_len = $urandom_range(1, 6);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          req_w1[i]   = $urandom;
          req_w2[i]   = $urandom;
          req_ctrl[i] = 3'($urandom_range(0, 7));
        end
      end
    end
    step();
    req = '0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
